// File: rtl/multidigit_holdstate.sv
// N-digit keypad hold stack with prescaled one-hot scan
// for a time-multiplexed seven-segment display.
module multidigit_holdstate #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int DIV         = 1,
  parameter int BLANK_EMPTY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic [DIGIT_W-1:0]           num_in,
  output logic [DIGIT_W-1:0]           num_out,
  output logic [DIGITS-1:0]            anodes,
  output logic                         blank,
  output logic [$clog2(DIGITS+1)-1:0]  fill_cnt
);

  localparam int SW = $clog2(DIGITS);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = $clog2(DIGITS + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(DIGITS);

  logic [DIGIT_W-1:0] slot_q [DIGITS];
  logic [DIGIT_W-1:0] slot_d [DIGITS];
  logic [FW-1:0]      fill_q, fill_d;
  logic [SW-1:0]      scan_q, scan_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               pre_tc;

  // digit stack: clr has priority over a same-cycle capture
  always_comb begin
    slot_d = slot_q;
    fill_d = fill_q;
    if (clr) begin
      for (int i = 0; i < DIGITS; i++)
        slot_d[i] = '0;
      fill_d = '0;
    end else if (en) begin
      slot_d[0] = num_in;
      for (int i = 1; i < DIGITS; i++)
        slot_d[i] = slot_q[i-1];
      if (fill_q != FILL_MAX)
        fill_d = fill_q + FW'(1);
    end
  end

  // scan runs free of en/clr; wraps explicitly at DIGITS-1
  always_comb begin
    pre_tc = (pre_q == PRE_LAST);
    pre_d  = pre_tc ? '0 : pre_q + PW'(1);
    scan_d = scan_q;
    if (pre_tc)
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++)
        slot_q[i] <= '0;
      fill_q <= '0;
      scan_q <= '0;
      pre_q  <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        slot_q[i] <= slot_d[i];
      fill_q <= fill_d;
      scan_q <= scan_d;
      pre_q  <= pre_d;
    end
  end

  always_comb begin
    num_out  = slot_q[scan_q];
    anodes   = ~(DIGITS'(1) << scan_q);
    blank    = (BLANK_EMPTY != 0) && (32'(scan_q) >= 32'(fill_q));
    fill_cnt = fill_q;
  end

endmodule

// File: tb/tb_multidigit_holdstate.sv
// Bench for multidigit_holdstate: vector table plus
// scoreboard against a behavioural model, DIV=1 and DIV=3.
module tb_multidigit_holdstate;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [3:0] num_in;

  logic [3:0] n1, n3;
  logic [3:0] a1, a3;
  logic       b1, b3;
  logic [2:0] f1, f3;

  int total = 0;
  int bad   = 0;

  multidigit_holdstate #(
    .DIGITS(4), .DIGIT_W(4), .DIV(1), .BLANK_EMPTY(1)
  ) u1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .num_in(num_in), .num_out(n1), .anodes(a1),
    .blank(b1), .fill_cnt(f1)
  );

  multidigit_holdstate #(
    .DIGITS(4), .DIGIT_W(4), .DIV(3), .BLANK_EMPTY(1)
  ) u3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .num_in(num_in), .num_out(n3), .anodes(a3),
    .blank(b3), .fill_cnt(f3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] n1;
    logic [3:0] a1;
    logic       b1;
    logic [2:0] f1;
    logic [3:0] n3;
    logic [3:0] a3;
    logic       b3;
    logic [2:0] f3;
  } exp_t;

  typedef struct {
    logic       e;
    logic       c;
    logic [3:0] d;
    int         fill;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  logic [3:0] m_slot [4];
  int m_fill, s1, s3, p3;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_slot[i] = '0;
    m_fill = 0;
    s1 = 0;
    s3 = 0;
    p3 = 0;
  endtask

  function automatic logic [3:0] sel(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic step(input logic e, input logic c,
                      input logic [3:0] d);
    exp_t x, g;
    en = e;
    clr = c;
    num_in = d;
    if (c) begin
      for (int i = 0; i < 4; i++) m_slot[i] = '0;
      m_fill = 0;
    end else if (e) begin
      for (int i = 3; i > 0; i--) m_slot[i] = m_slot[i-1];
      m_slot[0] = d;
      if (m_fill < 4) m_fill++;
    end
    s1 = (s1 + 1) % 4;
    if (p3 == 2) begin
      p3 = 0;
      s3 = (s3 + 1) % 4;
    end else begin
      p3++;
    end
    x.n1 = m_slot[s1];
    x.a1 = sel(s1);
    x.b1 = (s1 >= m_fill);
    x.f1 = 3'(m_fill);
    x.n3 = m_slot[s3];
    x.a3 = sel(s3);
    x.b3 = (s3 >= m_fill);
    x.f3 = 3'(m_fill);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      check("num_out1", n1, g.n1);
      check("anodes1", a1, g.a1);
      check("blank1", b1, g.b1);
      check("fill1", f1, g.f1);
      check("num_out3", n3, g.n3);
      check("anodes3", a3, g.a3);
      check("blank3", b3, g.b3);
      check("fill3", f3, g.f3);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an1"}, a1, 4'b1110);
    check({tag, "_num1"}, n1, 4'h0);
    check({tag, "_bl1"}, b1, 1'b1);
    check({tag, "_fc1"}, f1, 3'd0);
    check({tag, "_an3"}, a3, 4'b1110);
    check({tag, "_num3"}, n3, 4'h0);
    check({tag, "_bl3"}, b3, 1'b1);
    check({tag, "_fc3"}, f3, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    num_in = '0;

    // reset scan
    repeat (4) tbl.push_back('{1'b0, 1'b0, 4'h0, 0});
    // A,7,3 with gaps
    tbl.push_back('{1'b1, 1'b0, 4'hA, 1});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 1});
    tbl.push_back('{1'b1, 1'b0, 4'h7, 2});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 2});
    tbl.push_back('{1'b1, 1'b0, 4'h3, 3});
    repeat (4) tbl.push_back('{1'b0, 1'b0, 4'h0, 3});
    // clear then overfill 1..6
    tbl.push_back('{1'b0, 1'b1, 4'h0, 0});
    tbl.push_back('{1'b1, 1'b0, 4'h1, 1});
    tbl.push_back('{1'b1, 1'b0, 4'h2, 2});
    tbl.push_back('{1'b1, 1'b0, 4'h3, 3});
    tbl.push_back('{1'b1, 1'b0, 4'h4, 4});
    tbl.push_back('{1'b1, 1'b0, 4'h5, 4});
    tbl.push_back('{1'b1, 1'b0, 4'h6, 4});
    repeat (4) tbl.push_back('{1'b0, 1'b0, 4'h0, 4});
    // clr beats en
    tbl.push_back('{1'b1, 1'b1, 4'hF, 0});
    repeat (4) tbl.push_back('{1'b0, 1'b0, 4'h0, 0});

    #12;
    check_reset_state("rst0");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    foreach (tbl[k]) begin
      step(tbl[k].e, tbl[k].c, tbl[k].d);
      check($sformatf("tbl_fill[%0d]", k), f1, tbl[k].fill);
    end

    // DIV=3: each select held 3 clocks, 12-clock rotation
    reset = 1'b0;
    #1;
    check_reset_state("rst1");
    reset = 1'b1;
    model_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 4'h0);
      check($sformatf("div3_an[%0d]", k), a3, sel((k / 3) % 4));
    end

    // async reset mid-scan with scan_idx=2 on DIV=3
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'h8);
    step(1'b1, 1'b0, 4'h7);
    repeat (4) step(1'b0, 1'b0, 4'h0);
    check("pre_rst_an3", a3, 4'b1011);
    check("pre_rst_num3", n3, 4'h9);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("rst_mid");
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
